axi_tdd_ng_counter: RTL and testbench
=====================================

// Module: axi_tdd_ng_counter
// PURPOSE
// Timing core of the TDD engine. Consumes the control-register values
// (enable, sync mode, burst count, startup delay, frame length) and runs the
// IDLE/ARMED/WAITING/RUNNING state machine. Produces the frame reference
// counter and the current state for the downstream per-channel on/off
// comparators and for the STATUS register readback.
// PARAMETERS
// REGISTER_WIDTH     32  width of startup delay, frame length and reference counter
// BURST_COUNT_WIDTH  32  width of the burst count register
// PORTS
// clk                 in   1                  core clock
// resetn              in   1                  asynchronous active-low reset
// tdd_enable          in   1                  CONTROL.enable, level
// tdd_sync_rst        in   1                  CONTROL.sync_reset: a sync restarts a running frame
// tdd_sync            in   1                  sync pulse (int|ext|soft, OR-ed upstream), 1 cycle
// tdd_burst_count     in   BURST_COUNT_WIDTH  frames per burst; 0 = infinite
// tdd_startup_delay   in   REGISTER_WIDTH     cycles from sync to frame start
// tdd_frame_length    in   REGISTER_WIDTH     terminal count (frame = value+1 cycles)
// tdd_cstate          out  2                  state_t, current state
// tdd_counter         out  REGISTER_WIDTH     frame reference counter
// tdd_endof_frame     out  1                  1-cycle pulse on last cycle of each frame
// tdd_endof_burst     out  1                  1-cycle pulse on last cycle of a finite burst
// BEHAVIOUR
// - Reset: state IDLE, tdd_counter 0, burst counter 0, both pulses 0. All outputs registered.
// - Priority each cycle: !tdd_enable > sync handling > counting.
// - !tdd_enable in any state: next cycle IDLE, counter 0, no pulses.
// - IDLE: counter 0. tdd_enable=1 -> ARMED next cycle.
// - ARMED: counter 0. On tdd_sync: burst counter loaded with tdd_burst_count;
//   -> WAITING if tdd_startup_delay!=0, else RUNNING. Sync in the IDLE->ARMED cycle is ignored.
// - WAITING: counter counts 0..D-1 (D = tdd_startup_delay). At counter==D-1:
//   -> RUNNING, counter 0. WAITING therefore lasts exactly D cycles.
// - RUNNING: counter increments. At counter==tdd_frame_length: counter 0,
//   tdd_endof_frame=1. Then, if burst counter==1: tdd_endof_burst=1 and state
//   -> ARMED (re-arms for the next sync). Else if burst counter>1, decrement it.
//   Burst counter 0 never decrements (infinite).
// - Frame length 0: every RUNNING cycle is a frame end (pulse held high).
// - Counter above terminal count (register shrunk mid-frame): wrap at the
//   next compare using >=, never free-run to overflow.
// - tdd_sync in WAITING/RUNNING: if tdd_sync_rst=1, behave as in ARMED (reload
//   burst, restart delay/frame, no end pulses that cycle); if 0, ignore.
// - Frame end and sync-restart in same cycle with tdd_sync_rst=1: restart wins.
// - tdd_frame_length/tdd_startup_delay are used live (CDC done upstream);
//   tdd_burst_count is only sampled at sync.
// - Async reset mid-frame: all outputs return to reset values immediately.
// STRUCTURE
// - state_t and its encodings come from axi_tdd_ng_pkg; no new package types.
// - Single module, no sub-modules; one next-state block, one registered
//   datapath (counter, burst counter, pulses).
// TESTING
// 1 Reset: resetn=0 mid-RUNNING -> state IDLE, counter 0, pulses 0 same cycle.
// 2 Enable, delay=3, length=4, burst=2, sync -> 3 WAITING cycles, then two
//   5-cycle frames (counter 0..4), endof_frame at each 4, endof_burst on 2nd, ARMED.
// 3 delay=0, burst=0, length=9 -> RUNNING the cycle after sync; endof_frame
//   every 10 cycles for 1000 cycles; never returns to ARMED.
// 4 sync_rst=1, sync at counter=6 of length=9 -> counter 0 (or WAITING if delay>0),
//   burst reloaded, no endof_frame; sync_rst=0 -> sync has no effect.
// 5 Deassert enable in WAITING and in RUNNING -> IDLE next cycle, counter 0;
//   re-enable + sync restarts cleanly.
// 6 length=0 -> endof_frame held 1; length reduced 9->2 at counter=5 -> wrap next cycle.

Source files
------------

// File: rtl/axi_tdd_ng_pkg.sv
// Shared types for the TDD engine: the timing-core state encoding.
package axi_tdd_ng_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    WAITING = 2'b10,
    RUNNING = 2'b11
  } state_t;

endpackage

// File: rtl/axi_tdd_ng_counter.sv
// TDD timing core: IDLE/ARMED/WAITING/RUNNING sequencer with frame reference counter.
// Latency: one cycle from any input to the registered outputs.
// Backpressure: none; free-running once armed and synced, live register values.
module axi_tdd_ng_counter
  import axi_tdd_ng_pkg::*;
#(
  parameter int REGISTER_WIDTH    = 32,
  parameter int BURST_COUNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         tdd_enable,
  input  logic                         tdd_sync_rst,
  input  logic                         tdd_sync,
  input  logic [BURST_COUNT_WIDTH-1:0] tdd_burst_count,
  input  logic [REGISTER_WIDTH-1:0]    tdd_startup_delay,
  input  logic [REGISTER_WIDTH-1:0]    tdd_frame_length,
  output logic [1:0]                   tdd_cstate,
  output logic [REGISTER_WIDTH-1:0]    tdd_counter,
  output logic                         tdd_endof_frame,
  output logic                         tdd_endof_burst
);

  localparam logic [REGISTER_WIDTH:0]      CNT_ONE   = {{REGISTER_WIDTH{1'b0}}, 1'b1};
  localparam logic [BURST_COUNT_WIDTH-1:0] BURST_ONE = {{(BURST_COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                         cstate, nstate;
  logic [REGISTER_WIDTH-1:0]      counter, counter_n;
  logic [BURST_COUNT_WIDTH-1:0]   burst, burst_n;
  logic                           eof_n, eob_n;
  logic                           restart, delay_done, frame_end;
  logic [REGISTER_WIDTH:0]        counter_inc;

  always_comb begin
    nstate      = cstate;
    counter_n   = counter;
    burst_n     = burst;
    counter_inc = {1'b0, counter} + CNT_ONE;
    restart     = tdd_sync && ((cstate == ARMED) ||
                  (tdd_sync_rst && ((cstate == WAITING) || (cstate == RUNNING))));
    // >= rather than == so a register shrunk below the count still terminates
    delay_done  = counter_inc >= {1'b0, tdd_startup_delay};
    frame_end   = counter >= tdd_frame_length;

    if (!tdd_enable) begin
      nstate    = IDLE;
      counter_n = '0;
      burst_n   = '0;
    end else if (cstate == IDLE) begin
      nstate    = ARMED;
      counter_n = '0;
    end else if (restart) begin
      burst_n   = tdd_burst_count;
      counter_n = '0;
      nstate    = (tdd_startup_delay != '0) ? WAITING : RUNNING;
    end else begin
      case (cstate)
        WAITING: begin
          if (delay_done) begin
            nstate    = RUNNING;
            counter_n = '0;
          end else begin
            counter_n = counter_inc[REGISTER_WIDTH-1:0];
          end
        end
        RUNNING: begin
          if (frame_end) begin
            counter_n = '0;
            if (burst == BURST_ONE) begin
              nstate = ARMED;
            end else if (burst != '0) begin
              burst_n = burst - BURST_ONE;
            end
          end else begin
            counter_n = counter_inc[REGISTER_WIDTH-1:0];
          end
        end
        default: counter_n = '0;
      endcase
    end

    // Pulses are registered alongside the counter value they describe.
    eof_n = (nstate == RUNNING) && (counter_n >= tdd_frame_length);
    eob_n = eof_n && (burst_n == BURST_ONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cstate          <= IDLE;
      counter         <= '0;
      burst           <= '0;
      tdd_endof_frame <= 1'b0;
      tdd_endof_burst <= 1'b0;
    end else begin
      cstate          <= nstate;
      counter         <= counter_n;
      burst           <= burst_n;
      tdd_endof_frame <= eof_n;
      tdd_endof_burst <= eob_n;
    end
  end

  assign tdd_cstate  = cstate;
  assign tdd_counter = counter;

endmodule

// File: tb/tb_axi_tdd_ng_counter.sv
// Randomized and directed checks of axi_tdd_ng_counter against a cycle-level reference model.
module tb_axi_tdd_ng_counter;
  import axi_tdd_ng_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        tdd_enable, tdd_sync_rst, tdd_sync;
  logic [31:0] tdd_burst_count, tdd_startup_delay, tdd_frame_length;
  logic [1:0]  tdd_cstate;
  logic [31:0] tdd_counter;
  logic        tdd_endof_frame, tdd_endof_burst;

  int checks = 0;
  int errors = 0;

  // reference model: what the outputs should show after the latest edge
  state_t m_state;
  longint m_cnt, m_burst;
  bit     m_eof, m_eob;

  axi_tdd_ng_counter #(.REGISTER_WIDTH(32), .BURST_COUNT_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .tdd_enable(tdd_enable), .tdd_sync_rst(tdd_sync_rst),
    .tdd_sync(tdd_sync), .tdd_burst_count(tdd_burst_count),
    .tdd_startup_delay(tdd_startup_delay), .tdd_frame_length(tdd_frame_length),
    .tdd_cstate(tdd_cstate), .tdd_counter(tdd_counter),
    .tdd_endof_frame(tdd_endof_frame), .tdd_endof_burst(tdd_endof_burst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = IDLE; m_cnt = 0; m_burst = 0; m_eof = 0; m_eob = 0;
  endtask

  // One clock of the behavioural rules, using the inputs held across the edge.
  task automatic model_edge();
    longint d, l;
    bit sync_hit;
    d = longint'(tdd_startup_delay);
    l = longint'(tdd_frame_length);
    sync_hit = tdd_sync && (m_state == ARMED ||
               (tdd_sync_rst && (m_state == WAITING || m_state == RUNNING)));
    if (!tdd_enable) begin
      m_state = IDLE; m_cnt = 0; m_burst = 0;
    end else if (m_state == IDLE) begin
      m_state = ARMED; m_cnt = 0;
    end else if (sync_hit) begin
      m_burst = longint'(tdd_burst_count);
      m_cnt   = 0;
      m_state = (d != 0) ? WAITING : RUNNING;
    end else if (m_state == WAITING) begin
      if (m_cnt + 1 >= d) begin m_state = RUNNING; m_cnt = 0; end
      else m_cnt++;
    end else if (m_state == RUNNING) begin
      if (m_cnt >= l) begin
        m_cnt = 0;
        if (m_burst == 1) m_state = ARMED;
        else if (m_burst > 1) m_burst--;
      end else m_cnt++;
    end
    m_eof = (m_state == RUNNING) && (m_cnt >= l);
    m_eob = m_eof && (m_burst == 1);
  endtask

  task automatic compare();
    chk("state", longint'(tdd_cstate), longint'(m_state));
    chk("counter", longint'(tdd_counter), m_cnt);
    chk("endof_frame", longint'(tdd_endof_frame), longint'(m_eof));
    chk("endof_burst", longint'(tdd_endof_burst), longint'(m_eob));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    tdd_sync = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_cnt(input string tag, input state_t st, input longint target);
    int budget = 200;
    while (!(m_state == st && m_cnt == target) && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic cfg(input longint d, input longint l, input longint b);
    tdd_startup_delay = 32'(d);
    tdd_frame_length  = 32'(l);
    tdd_burst_count   = 32'(b);
  endtask

  task automatic pulse_sync();
    tdd_sync = 1'b1;
    step();
  endtask

  int eof_seen, eob_seen, armed_seen;

  initial begin
    resetn = 1'b0;
    tdd_enable = 0; tdd_sync_rst = 0; tdd_sync = 0;
    cfg(0, 0, 0);
    model_reset();
    #23;
    compare();
    @(negedge clk) resetn = 1'b1;

    // finite burst: delay 3, 5-cycle frames, 2 frames
    cfg(3, 4, 2);
    tdd_enable = 1'b1;
    tdd_sync = 1'b1;         // lands in the IDLE->ARMED cycle and must be ignored
    step();
    chk("ignored_sync_state", longint'(tdd_cstate), longint'(ARMED));
    run(2);
    eof_seen = 0; eob_seen = 0;
    pulse_sync();
    for (int i = 0; i < 16; i++) begin
      eof_seen += int'(tdd_endof_frame);
      eob_seen += int'(tdd_endof_burst);
      step();
    end
    chk("burst_eof_count", eof_seen, 2);
    chk("burst_eob_count", eob_seen, 1);
    chk("burst_rearmed", longint'(tdd_cstate), longint'(ARMED));

    // infinite burst, no delay: one frame end every 10 cycles
    cfg(0, 9, 0);
    pulse_sync();
    chk("nodelay_running", longint'(tdd_cstate), longint'(RUNNING));
    eof_seen = 0; armed_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i > 0) step();
      eof_seen   += int'(tdd_endof_frame);
      armed_seen += int'(tdd_cstate == 2'(ARMED));
    end
    chk("infinite_eof_count", eof_seen, 100);
    chk("infinite_never_armed", armed_seen, 0);

    // sync restart mid-frame, then sync ignored without sync_rst
    cfg(0, 9, 3);
    tdd_sync_rst = 1'b1;
    wait_cnt("restart", RUNNING, 6);
    pulse_sync();
    chk("restart_counter", longint'(tdd_counter), 0);
    chk("restart_no_eof", longint'(tdd_endof_frame), 0);
    tdd_sync_rst = 1'b0;
    wait_cnt("ignore", RUNNING, 6);
    pulse_sync();
    chk("ignored_sync_counter", longint'(tdd_counter), 7);
    tdd_sync_rst = 1'b1;
    cfg(2, 9, 3);
    wait_cnt("restart_delay", RUNNING, 6);
    pulse_sync();
    chk("restart_to_waiting", longint'(tdd_cstate), longint'(WAITING));
    run(3);

    // disable in WAITING and in RUNNING
    cfg(5, 9, 0);
    pulse_sync();
    run(2);
    tdd_enable = 1'b0;
    step();
    chk("dis_wait_idle", longint'(tdd_cstate), longint'(IDLE));
    tdd_enable = 1'b1;
    run(2);
    cfg(0, 9, 0);
    pulse_sync();
    wait_cnt("dis_run", RUNNING, 4);
    tdd_enable = 1'b0;
    step();
    chk("dis_run_counter", longint'(tdd_counter), 0);
    tdd_enable = 1'b1;
    run(2);
    pulse_sync();
    run(12);

    // zero-length frames, then a frame length shrunk mid-frame
    cfg(0, 0, 0);
    pulse_sync();
    for (int i = 0; i < 5; i++) begin
      chk("len0_eof_held", longint'(tdd_endof_frame), 1);
      step();
    end
    cfg(0, 9, 0);
    pulse_sync();
    wait_cnt("shrink", RUNNING, 5);
    tdd_frame_length = 32'd2;
    step();
    chk("shrink_wrap", longint'(tdd_counter), 0);
    run(8);

    // asynchronous reset in the middle of a frame
    #3 resetn = 1'b0;
    model_reset();
    #1;
    chk("async_rst_state", longint'(tdd_cstate), longint'(IDLE));
    compare();
    @(negedge clk) resetn = 1'b1;
    run(3);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tdd_enable   = ($urandom_range(0, 99) < 98);
      tdd_sync_rst = 1'($urandom_range(0, 1));
      tdd_sync     = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 29) == 0) tdd_frame_length = 32'($urandom_range(0, 6));
      if ($urandom_range(0, 29) == 0) tdd_startup_delay = 32'($urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) tdd_burst_count = 32'($urandom_range(0, 3));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
